// File: rtl/tinyalu_pkg.sv
// Shared types for the tinyalu responder: operation encoding, FSM states and
// the default multiplier latency.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int MUL_LATENCY_DEF = 3;

endpackage

// File: rtl/tinyalu_mult.sv
// Multi-cycle multiplier: captures operands on load, counts down the latency
// and registers the product together with a one-cycle mult_done pulse.
module tinyalu_mult #(
    parameter int DATA_W  = 8,
    parameter int LATENCY = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_load,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic                o_fire,
    output logic                o_mult_done,
    output logic [2*DATA_W-1:0] o_product
);

    localparam int CNT_W = 4;

    logic                r_busy;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [2*DATA_W-1:0] r_product;
    logic                r_mult_done;

    // High on the edge that completes the operation; lets the top switch its
    // result select in the same edge that the product is written.
    assign o_fire      = r_busy && (r_cnt == CNT_W'(1));
    assign o_mult_done = r_mult_done;
    assign o_product   = r_product;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_product   <= '0;
            r_mult_done <= 1'b0;
        end else begin
            r_mult_done <= 1'b0;
            if (i_load) begin
                r_a    <= i_a;
                r_b    <= i_b;
                r_cnt  <= CNT_W'(LATENCY - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (r_cnt == CNT_W'(1)) begin
                    r_product   <= {{DATA_W{1'b0}}, r_a} * {{DATA_W{1'b0}}, r_b};
                    r_mult_done <= 1'b1;
                    r_busy      <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tinyalu.sv
// tinyalu responder: single-cycle add/and/xor datapath, multi-cycle multiply
// via tinyalu_mult, and the IDLE/MUL/ACK handshake FSM.
module tinyalu
    import tinyalu_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    input  logic [2:0]          op,
    input  logic                start,
    output logic                done,
    output logic [2*DATA_W-1:0] result
);

    state_t              r_state;
    logic                r_alu_done;
    logic [2*DATA_W-1:0] r_alu_result;
    logic                r_use_mul;

    operation_t          w_op;
    logic [2*DATA_W-1:0] w_alu;
    logic                w_single;
    logic                w_mult_load;
    logic                w_mult_fire;
    logic                w_mult_done;
    logic [2*DATA_W-1:0] w_product;

    assign w_op = operation_t'(op);

    always_comb begin
        w_alu    = '0;
        w_single = 1'b0;
        case (w_op)
            add_op: begin
                w_alu    = {{(DATA_W-1){1'b0}}, {1'b0, A} + {1'b0, B}};
                w_single = 1'b1;
            end
            and_op: begin
                w_alu    = {{DATA_W{1'b0}}, A & B};
                w_single = 1'b1;
            end
            xor_op: begin
                w_alu    = {{DATA_W{1'b0}}, A ^ B};
                w_single = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_mult_load = (r_state == IDLE) && start && (w_op == mul_op);

    tinyalu_mult #(
        .DATA_W  (DATA_W),
        .LATENCY (MUL_LATENCY)
    ) u_mult (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_mult_load),
        .i_a         (A),
        .i_b         (B),
        .o_fire      (w_mult_fire),
        .o_mult_done (w_mult_done),
        .o_product   (w_product)
    );

    // Both done sources are flops and never overlap; the select flips only on
    // the edge that raises the corresponding done.
    assign done   = r_alu_done | w_mult_done;
    assign result = r_use_mul ? w_product : r_alu_result;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_alu_done   <= 1'b0;
            r_alu_result <= '0;
            r_use_mul    <= 1'b0;
        end else begin
            r_alu_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && w_single) begin
                        r_alu_result <= w_alu;
                        r_alu_done   <= 1'b1;
                        r_use_mul    <= 1'b0;
                        r_state      <= ACK;
                    end else if (w_mult_load) begin
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    if (w_mult_fire) begin
                        r_use_mul <= 1'b1;
                    end
                    // The done cycle behaves as the first ACK cycle.
                    if (w_mult_done) begin
                        r_state <= start ? ACK : IDLE;
                    end
                end
                ACK: begin
                    if (!start) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tinyalu.md
Name: tinyalu

Overview:
- Responder end of the tinyalu_bfm operation protocol; this is the DUT that the random tester drives through the BFM.
- Accepts an operation (A, B, op) on a start request and returns a 16-bit result with a one-cycle done pulse.
- add/and/xor complete in 1 cycle; mul completes in MUL_LATENCY cycles.
- Sits directly under the BFM in the top-level testbench.

Parameters:
- DATA_W, 8, operand width; result width is 2*DATA_W.
- MUL_LATENCY, 3, clock edges from start sample to done for mul_op; legal range 2..8.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- A  input  DATA_W  operand A; sampled when start is accepted.
- B  input  DATA_W  operand B; sampled when start is accepted.
- op  input  3  operation_t encoding: 000 no_op, 001 add_op, 010 and_op, 011 xor_op, 100 mul_op, 111 rst_op; 101/110 illegal.
- start  input  1  request; held by the master until done is seen.
- done  output  1  one-cycle completion pulse.
- result  output  2*DATA_W  result of the last completed operation.

Behaviour:
- Reset: reset_n low asynchronously clears state to IDLE, done=0, result=0 and captured operands. Reset mid-mul aborts the operation; no done is issued.
- States: IDLE, MUL, ACK.
- IDLE:
  - start=1 with add/and/xor at edge k: result registered at edge k, done=1 for the cycle after edge k, go to ACK.
  - start=1 with mul_op: capture A and B, load cnt=MUL_LATENCY-1, go to MUL.
  - start=1 with no_op, rst_op or an illegal op: no action, no done, stay IDLE.
  - start=0: stay IDLE.
- MUL:
  - cnt decrements each edge.
  - On the edge where cnt==1: result=A_cap*B_cap, done=1, go to ACK.
  - Total: mul done is registered at edge k+MUL_LATENCY-1, i.e. latency 3 edges by default counting the accepting edge.
  - Changes on A, B, op or start during MUL are ignored.
- ACK:
  - done returns to 0 on the first edge.
  - start=0 → IDLE; start=1 → stay ACK.
  - This means a start left high after done never retriggers an operation.
- Arithmetic:
  - add: {7'b0, A+B}, 9-bit sum with carry in bit 8, zero-extended.
  - and / xor: zero-extended into result[15:8].
  - mul: full 16-bit unsigned product.
- result holds its value between done pulses and changes only on the edge that raises done.
- done is never high for two consecutive cycles.
- Back-to-back: the master drops start on the done cycle. The next start is accepted no earlier than 2 edges after done rises, via ACK→IDLE.

Decomposition:
- tinyalu_pkg holds:
  - operation_t, the 3-bit enum with the values above;
  - the state enum {IDLE, MUL, ACK};
  - a localparam default for MUL_LATENCY.
- One sub-module, tinyalu_mult:
  - captures operands on load;
  - counts latency;
  - registers the product and raises a one-cycle mult_done.
- The top module keeps the single-cycle datapath, the FSM and the output register.

Test Plan:
- add: reset_n low 2 cycles, then start with A=8'hFF, B=8'hFF, op=add_op → done high 1 cycle after the accepting edge, result=16'h01FE; done low the next cycle.
- and / xor: A=8'hF0, B=8'h3C, op=and_op → 16'h0030; then op=xor_op → 16'h00CC. Each op is back-to-back with start dropped on done, and the second is accepted 2 edges after the first done.
- mul: A=8'hFF, B=8'hFF, op=mul_op → done exactly 2 edges after the accepting edge (MUL_LATENCY=3), result=16'hFE01. A and B are changed to 0 during MUL, and the result must be unaffected.
- no_op / rst_op / illegal ops: start with no_op, then op=3'b101, then rst_op, each held 3 cycles → done stays 0 and result keeps its previous value 16'hFE01.
- Start held high: start held for 5 cycles after an add with A=1, B=2 → exactly one done pulse, result=16'h0003, FSM remains in ACK until start drops.
- Reset mid-mul: reset_n pulsed low on the cycle after mul_op is accepted with A=3, B=4 → done never rises, result=0. A following mul with A=3, B=4 after reset deassertion → result=16'h000C.
